ysyx_22050133_axi_arbiter: RTL and testbench
============================================

// Module: ysyx_22050133_axi_arbiter
// PURPOSE
//  2:1 AXI4 arbiter inside ysyx_22050133; drives the core's io_master port to the AXI slave memory.
//  Merges IFU (read-only) and LSU (read+write) requests onto the single downstream master port.
//  Round-robin read arbitration. LSU-only write path. Store-before-load ordering for the LSU.
// PARAMETERS
//  ADDR_W    32  address width, all ports
//  DATA_W    64  data width; strobe width is DATA_W/8
//  ID_W      4   AXI ID width
//  IFU_ID    0   arid driven downstream for IFU reads
//  LSU_ID    1   arid/awid driven downstream for LSU traffic
// PORTS
//  clk        in   1  clock; all state updates on posedge
//  rst        in   1  asynchronous reset, active-high
//  ifu_ar{valid,ready,id,addr,len,size,burst}  in/out/in...  1/1/ID_W/ADDR_W/8/3/2  IFU read address
//  ifu_r{valid,ready,id,resp,data,last}        out/in/out..  1/1/ID_W/2/DATA_W/1    IFU read data
//  lsu_ar*, lsu_r*     same shape as ifu_ar*/ifu_r*                                 LSU read
//  lsu_aw{valid,ready,id,addr,len,size,burst}  in/out/in...  as AR                  LSU write address
//  lsu_w{valid,ready,data,strb,last}           in/out/in..   1/1/DATA_W/DATA_W/8/1  LSU write data
//  lsu_b{valid,ready,id,resp}                  out/in/out    1/1/ID_W/2             LSU write response
//  axi_ar_*_o/axi_ar_ready_i, axi_r_*_i/axi_r_ready_o,
//  axi_aw_*_o/axi_aw_ready_i, axi_w_*_o/axi_w_ready_i, axi_b_*_i/axi_b_ready_o      downstream AXI4 master
// BEHAVIOUR
//  Reset: every *valid and *ready output is 0. Read FSM=R_IDLE. Write FSM=W_IDLE. rr_ptr=0 (IFU wins the next tie).
//  Read FSM: R_IDLE -> R_IFU | R_LSU; R_IFU/R_LSU -> R_IDLE.
//   - R_IDLE: sample the arvalids and register the grant; nothing is driven downstream.
//     Eligible: ifu_arvalid; lsu_arvalid only when write FSM==W_IDLE.
//     Both eligible: grant goes to rr_ptr. One eligible: grant goes to it.
//   - Granted state: axi_ar_valid_o = granted arvalid & ~ar_done; AR payload passes through.
//     arid_o = IFU_ID/LSU_ID. Upstream arid is latched on the AR handshake.
//   - ar_done is set on the axi AR handshake; granted arready = axi_ar_ready_i & ~ar_done.
//   - R beats are routed to the granted master only, with rid = latched id.
//     axi_r_ready_o = granted rready. The other master sees rvalid=0 and arready=0.
//   - On the R handshake with rlast: go to R_IDLE, clear ar_done, set rr_ptr = the other master.
//   - Latency: arvalid in R_IDLE -> axi_ar_valid_o 1 cycle later. R path is combinational (0 cycles).
//  Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
//   - W_IDLE: AW passes through (awid_o=LSU_ID, upstream awid latched); lsu_wready=0.
//     The AW handshake moves to W_DATA.
//   - W_DATA: W passes through; awvalid_o=0. The W handshake with wlast moves to W_RESP.
//   - W_RESP: B is routed to the LSU with bid = latched id. The B handshake moves to W_IDLE.
//  Ordering: an LSU read is never granted while the write FSM != W_IDLE. IFU reads are unaffected.
//  Read and write FSMs run independently; the IFU read and the LSU write may overlap.
//  rresp/bresp pass through unchanged. Errors are not interpreted and never change FSM flow.
//  An upstream master must hold AR/AW payload stable while valid (AXI rule); nothing is buffered.
//  Reset mid-burst: all outputs drop asynchronously. The in-flight transaction is abandoned, not replayed.
// STRUCTURE
//  ysyx_22050133_axi_pkg: AXI_BURST_INCR/RESP_* constants, R_IDLE/R_IFU/R_LSU and W_IDLE/W_DATA/W_RESP encodings.
//  Sub-module ysyx_22050133_rr_arb2: 2-request round-robin picker (req[1:0], ptr) -> onehot grant.
//  Everything else lives in this module.
// TESTING
//  1. IFU AR addr=0x8000_0000 len=3 alone -> axi AR 1 cycle later, arid_o=0.
//     4 beats go to IFU with rid = IFU id; lsu_rvalid stays 0; R_IDLE after rlast.
//  2. After reset, IFU and LSU arvalid in the same cycle -> IFU served first, then LSU.
//     A third simultaneous pair -> IFU again (rr_ptr back to 0).
//  3. LSU AW 0x8000_1000 len=0 + W strb=0xFF, then LSU AR 0x8000_1000 while in W_RESP
//     -> LSU AR is not granted until the B handshake. A concurrent IFU AR is granted.
//  4. IFU rready low for 3 cycles mid-burst -> axi_r_ready_o low for exactly those cycles, no beat lost.
//  5. rst asserted after 2 of 4 beats -> all valids/readies 0 immediately; both FSMs idle.
//     The first post-reset tie is granted to IFU.
//  6. Downstream rresp=2'b10 and bresp=2'b11 -> forwarded unchanged; the FSMs complete normally.

Source files
------------

// File: rtl/ysyx_22050133_axi_pkg.sv
// Shared AXI constants and the read/write FSM state encodings for the arbiter.
package ysyx_22050133_axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY      = 2'b00;
   localparam logic [1:0] RESP_EXOKAY    = 2'b01;
   localparam logic [1:0] RESP_SLVERR    = 2'b10;
   localparam logic [1:0] RESP_DECERR    = 2'b11;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_IFU  = 2'd1,
      R_LSU  = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

endpackage

// File: rtl/ysyx_22050133_rr_arb2.sv
// Two-request round-robin picker, purely combinational; ptr=1 favours req[1] on a tie.
module ysyx_22050133_rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (&req) gnt = ptr ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/ysyx_22050133_axi_arbiter.sv
// 2:1 AXI4 arbiter (IFU read, LSU read/write) onto one master port; grant registered 1 cycle, R/W/B paths
// combinational; no buffering, backpressure passes straight through to the granted master.
module ysyx_22050133_axi_arbiter
   import ysyx_22050133_axi_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4,
   parameter int IFU_ID = 0,
   parameter int LSU_ID = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_arvalid,
   output logic                ifu_arready,
   input  logic [ID_W-1:0]     ifu_arid,
   input  logic [ADDR_W-1:0]   ifu_araddr,
   input  logic [7:0]          ifu_arlen,
   input  logic [2:0]          ifu_arsize,
   input  logic [1:0]          ifu_arburst,
   output logic                ifu_rvalid,
   input  logic                ifu_rready,
   output logic [ID_W-1:0]     ifu_rid,
   output logic [1:0]          ifu_rresp,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic                ifu_rlast,
   input  logic                lsu_arvalid,
   output logic                lsu_arready,
   input  logic [ID_W-1:0]     lsu_arid,
   input  logic [ADDR_W-1:0]   lsu_araddr,
   input  logic [7:0]          lsu_arlen,
   input  logic [2:0]          lsu_arsize,
   input  logic [1:0]          lsu_arburst,
   output logic                lsu_rvalid,
   input  logic                lsu_rready,
   output logic [ID_W-1:0]     lsu_rid,
   output logic [1:0]          lsu_rresp,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_rlast,
   input  logic                lsu_awvalid,
   output logic                lsu_awready,
   input  logic [ID_W-1:0]     lsu_awid,
   input  logic [ADDR_W-1:0]   lsu_awaddr,
   input  logic [7:0]          lsu_awlen,
   input  logic [2:0]          lsu_awsize,
   input  logic [1:0]          lsu_awburst,
   input  logic                lsu_wvalid,
   output logic                lsu_wready,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   input  logic                lsu_wlast,
   output logic                lsu_bvalid,
   input  logic                lsu_bready,
   output logic [ID_W-1:0]     lsu_bid,
   output logic [1:0]          lsu_bresp,
   output logic                axi_ar_valid_o,
   input  logic                axi_ar_ready_i,
   output logic [ID_W-1:0]     axi_ar_id_o,
   output logic [ADDR_W-1:0]   axi_ar_addr_o,
   output logic [7:0]          axi_ar_len_o,
   output logic [2:0]          axi_ar_size_o,
   output logic [1:0]          axi_ar_burst_o,
   input  logic                axi_r_valid_i,
   output logic                axi_r_ready_o,
   input  logic [ID_W-1:0]     axi_r_id_i,
   input  logic [1:0]          axi_r_resp_i,
   input  logic [DATA_W-1:0]   axi_r_data_i,
   input  logic                axi_r_last_i,
   output logic                axi_aw_valid_o,
   input  logic                axi_aw_ready_i,
   output logic [ID_W-1:0]     axi_aw_id_o,
   output logic [ADDR_W-1:0]   axi_aw_addr_o,
   output logic [7:0]          axi_aw_len_o,
   output logic [2:0]          axi_aw_size_o,
   output logic [1:0]          axi_aw_burst_o,
   output logic                axi_w_valid_o,
   input  logic                axi_w_ready_i,
   output logic [DATA_W-1:0]   axi_w_data_o,
   output logic [DATA_W/8-1:0] axi_w_strb_o,
   output logic                axi_w_last_o,
   input  logic                axi_b_valid_i,
   output logic                axi_b_ready_o,
   input  logic [ID_W-1:0]     axi_b_id_i,
   input  logic [1:0]          axi_b_resp_i
);

   rd_state_t       rd_state, rd_next;
   wr_state_t       wr_state, wr_next;
   logic            ar_done, rr_ptr, sel_lsu;
   logic [ID_W-1:0] rid_q, bid_q;
   logic [1:0]      req, gnt;
   logic            unused_ids;

   // Downstream IDs are replaced by fixed per-master IDs, so the returned ones carry no information.
   assign unused_ids = ^{axi_r_id_i, axi_b_id_i};

   // Loads wait for any store in flight to fully complete (store-before-load).
   assign req = {lsu_arvalid & (wr_state == W_IDLE), ifu_arvalid};

   ysyx_22050133_rr_arb2 u_rr_arb2 (
      .req (req),
      .ptr (rr_ptr),
      .gnt (gnt)
   );

   assign sel_lsu        = (rd_state == R_LSU);
   assign axi_ar_id_o    = sel_lsu ? ID_W'(LSU_ID) : ID_W'(IFU_ID);
   assign axi_ar_addr_o  = sel_lsu ? lsu_araddr  : ifu_araddr;
   assign axi_ar_len_o   = sel_lsu ? lsu_arlen   : ifu_arlen;
   assign axi_ar_size_o  = sel_lsu ? lsu_arsize  : ifu_arsize;
   assign axi_ar_burst_o = sel_lsu ? lsu_arburst : ifu_arburst;

   assign ifu_rid   = rid_q;
   assign ifu_rresp = axi_r_resp_i;
   assign ifu_rdata = axi_r_data_i;
   assign ifu_rlast = axi_r_last_i;
   assign lsu_rid   = rid_q;
   assign lsu_rresp = axi_r_resp_i;
   assign lsu_rdata = axi_r_data_i;
   assign lsu_rlast = axi_r_last_i;

   always_comb begin
      rd_next        = rd_state;
      axi_ar_valid_o = 1'b0;
      axi_r_ready_o  = 1'b0;
      ifu_arready    = 1'b0;
      lsu_arready    = 1'b0;
      ifu_rvalid     = 1'b0;
      lsu_rvalid     = 1'b0;
      case (rd_state)
         R_IDLE: begin
            if (gnt[0])      rd_next = R_IFU;
            else if (gnt[1]) rd_next = R_LSU;
         end
         R_IFU: begin
            axi_ar_valid_o = ifu_arvalid & ~ar_done;
            ifu_arready    = axi_ar_ready_i & ~ar_done;
            ifu_rvalid     = axi_r_valid_i;
            axi_r_ready_o  = ifu_rready;
            if (axi_r_valid_i && ifu_rready && axi_r_last_i) rd_next = R_IDLE;
         end
         R_LSU: begin
            axi_ar_valid_o = lsu_arvalid & ~ar_done;
            lsu_arready    = axi_ar_ready_i & ~ar_done;
            lsu_rvalid     = axi_r_valid_i;
            axi_r_ready_o  = lsu_rready;
            if (axi_r_valid_i && lsu_rready && axi_r_last_i) rd_next = R_IDLE;
         end
         default: rd_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state <= R_IDLE;
         ar_done  <= 1'b0;
         rr_ptr   <= 1'b0;
         rid_q    <= '0;
      end else begin
         rd_state <= rd_next;
         if (axi_ar_valid_o && axi_ar_ready_i) begin
            ar_done <= 1'b1;
            rid_q   <= sel_lsu ? lsu_arid : ifu_arid;
         end
         if (axi_r_valid_i && axi_r_ready_o && axi_r_last_i) begin
            ar_done <= 1'b0;
            rr_ptr  <= (rd_state == R_IFU);
         end
      end
   end

   assign axi_aw_id_o    = ID_W'(LSU_ID);
   assign axi_aw_addr_o  = lsu_awaddr;
   assign axi_aw_len_o   = lsu_awlen;
   assign axi_aw_size_o  = lsu_awsize;
   assign axi_aw_burst_o = lsu_awburst;
   assign axi_w_data_o   = lsu_wdata;
   assign axi_w_strb_o   = lsu_wstrb;
   assign axi_w_last_o   = lsu_wlast;
   assign lsu_bid        = bid_q;
   assign lsu_bresp      = axi_b_resp_i;

   // AW is a pure pass-through in W_IDLE, so it must be gated by rst to drop during reset.
   always_comb begin
      wr_next        = wr_state;
      axi_aw_valid_o = 1'b0;
      lsu_awready    = 1'b0;
      axi_w_valid_o  = 1'b0;
      lsu_wready     = 1'b0;
      lsu_bvalid     = 1'b0;
      axi_b_ready_o  = 1'b0;
      case (wr_state)
         W_IDLE: begin
            axi_aw_valid_o = lsu_awvalid & ~rst;
            lsu_awready    = axi_aw_ready_i & ~rst;
            if (lsu_awvalid && axi_aw_ready_i) wr_next = W_DATA;
         end
         W_DATA: begin
            axi_w_valid_o = lsu_wvalid;
            lsu_wready    = axi_w_ready_i;
            if (lsu_wvalid && axi_w_ready_i && lsu_wlast) wr_next = W_RESP;
         end
         W_RESP: begin
            lsu_bvalid    = axi_b_valid_i;
            axi_b_ready_o = lsu_bready;
            if (axi_b_valid_i && lsu_bready) wr_next = W_IDLE;
         end
         default: wr_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_state <= W_IDLE;
         bid_q    <= '0;
      end else begin
         wr_state <= wr_next;
         if (axi_aw_valid_o && axi_aw_ready_i) bid_q <= lsu_awid;
      end
   end

endmodule

// File: tb/tb_ysyx_22050133_axi_arbiter.sv
// Directed bench: arbitration vector table plus hand sequences for burst stall, store-before-load,
// reset mid-burst and error-response pass-through.
module tb_ysyx_22050133_axi_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
   logic [3:0]  ifu_arid, ifu_rid;
   logic [31:0] ifu_araddr;
   logic [7:0]  ifu_arlen;
   logic [2:0]  ifu_arsize;
   logic [1:0]  ifu_arburst, ifu_rresp;
   logic [63:0] ifu_rdata;
   logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
   logic [3:0]  lsu_arid, lsu_rid;
   logic [31:0] lsu_araddr;
   logic [7:0]  lsu_arlen;
   logic [2:0]  lsu_arsize;
   logic [1:0]  lsu_arburst, lsu_rresp;
   logic [63:0] lsu_rdata;
   logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_wlast, lsu_bvalid, lsu_bready;
   logic [3:0]  lsu_awid, lsu_bid;
   logic [31:0] lsu_awaddr;
   logic [7:0]  lsu_awlen, lsu_wstrb;
   logic [2:0]  lsu_awsize;
   logic [1:0]  lsu_awburst, lsu_bresp;
   logic [63:0] lsu_wdata;
   logic        axi_ar_valid_o, axi_ar_ready_i, axi_r_valid_i, axi_r_ready_o, axi_r_last_i;
   logic [3:0]  axi_ar_id_o, axi_r_id_i;
   logic [31:0] axi_ar_addr_o;
   logic [7:0]  axi_ar_len_o;
   logic [2:0]  axi_ar_size_o;
   logic [1:0]  axi_ar_burst_o, axi_r_resp_i;
   logic [63:0] axi_r_data_i;
   logic        axi_aw_valid_o, axi_aw_ready_i, axi_w_valid_o, axi_w_ready_i, axi_w_last_o;
   logic        axi_b_valid_i, axi_b_ready_o;
   logic [3:0]  axi_aw_id_o, axi_b_id_i;
   logic [31:0] axi_aw_addr_o;
   logic [7:0]  axi_aw_len_o, axi_w_strb_o;
   logic [2:0]  axi_aw_size_o;
   logic [1:0]  axi_aw_burst_o, axi_b_resp_i;
   logic [63:0] axi_w_data_o;

   ysyx_22050133_axi_arbiter dut (
      .clk(clk), .rst(rst),
      .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_arid(ifu_arid),
      .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize),
      .ifu_arburst(ifu_arburst), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
      .ifu_rid(ifu_rid), .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata), .ifu_rlast(ifu_rlast),
      .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_arid(lsu_arid),
      .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize),
      .lsu_arburst(lsu_arburst), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
      .lsu_rid(lsu_rid), .lsu_rresp(lsu_rresp), .lsu_rdata(lsu_rdata), .lsu_rlast(lsu_rlast),
      .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awid(lsu_awid),
      .lsu_awaddr(lsu_awaddr), .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize),
      .lsu_awburst(lsu_awburst), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
      .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bid(lsu_bid), .lsu_bresp(lsu_bresp),
      .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i), .axi_ar_id_o(axi_ar_id_o),
      .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_len_o(axi_ar_len_o), .axi_ar_size_o(axi_ar_size_o),
      .axi_ar_burst_o(axi_ar_burst_o), .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o),
      .axi_r_id_i(axi_r_id_i), .axi_r_resp_i(axi_r_resp_i), .axi_r_data_i(axi_r_data_i),
      .axi_r_last_i(axi_r_last_i), .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i),
      .axi_aw_id_o(axi_aw_id_o), .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_len_o(axi_aw_len_o),
      .axi_aw_size_o(axi_aw_size_o), .axi_aw_burst_o(axi_aw_burst_o), .axi_w_valid_o(axi_w_valid_o),
      .axi_w_ready_i(axi_w_ready_i), .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o),
      .axi_w_last_o(axi_w_last_o), .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o),
      .axi_b_id_i(axi_b_id_i), .axi_b_resp_i(axi_b_resp_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic zero_inputs();
      ifu_arvalid = 0; ifu_arid = 0; ifu_araddr = 0; ifu_arlen = 0; ifu_arsize = 3'd3;
      ifu_arburst = 2'b01; ifu_rready = 0;
      lsu_arvalid = 0; lsu_arid = 0; lsu_araddr = 0; lsu_arlen = 0; lsu_arsize = 3'd3;
      lsu_arburst = 2'b01; lsu_rready = 0;
      lsu_awvalid = 0; lsu_awid = 0; lsu_awaddr = 0; lsu_awlen = 0; lsu_awsize = 3'd3;
      lsu_awburst = 2'b01; lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wlast = 0;
      lsu_bready = 0;
      axi_ar_ready_i = 0; axi_r_valid_i = 0; axi_r_id_i = 0; axi_r_resp_i = 0;
      axi_r_data_i = 0; axi_r_last_i = 0; axi_aw_ready_i = 0; axi_w_ready_i = 0;
      axi_b_valid_i = 0; axi_b_id_i = 0; axi_b_resp_i = 0;
   endtask

   // One single-beat read; both masters may request, exp_lsu names the expected winner.
   task automatic do_read(input logic iv, input logic lv, input logic [1:0] resp,
                          input logic exp_lsu, input int idx);
      @(negedge clk);
      ifu_arvalid = iv; lsu_arvalid = lv;
      ifu_araddr = 32'h8000_0100; lsu_araddr = 32'h8000_2200;
      ifu_arid = 4'h5; lsu_arid = 4'h9; ifu_arlen = 0; lsu_arlen = 0;
      #1 chk($sformatf("v%0d_idle_no_ar", idx), 64'(axi_ar_valid_o), 64'(0));
      @(negedge clk);
      chk($sformatf("v%0d_ar_valid", idx), 64'(axi_ar_valid_o), 64'(1));
      chk($sformatf("v%0d_ar_id", idx), 64'(axi_ar_id_o), exp_lsu ? 64'(1) : 64'(0));
      chk($sformatf("v%0d_ar_addr", idx), 64'(axi_ar_addr_o),
          exp_lsu ? 64'h8000_2200 : 64'h8000_0100);
      axi_ar_ready_i = 1;
      #1 chk($sformatf("v%0d_ifu_arready", idx), 64'(ifu_arready), 64'(!exp_lsu));
      chk($sformatf("v%0d_lsu_arready", idx), 64'(lsu_arready), 64'(exp_lsu));
      @(negedge clk);
      axi_ar_ready_i = 0; ifu_arvalid = 0; lsu_arvalid = 0; ifu_arid = 4'hF; lsu_arid = 4'hF;
      axi_r_valid_i = 1; axi_r_last_i = 1; axi_r_resp_i = resp; axi_r_data_i = 64'hD0 + 64'(idx);
      axi_r_id_i = 4'hE; ifu_rready = 1; lsu_rready = 1;
      #1 chk($sformatf("v%0d_ar_done", idx), 64'(axi_ar_valid_o), 64'(0));
      chk($sformatf("v%0d_ifu_rvalid", idx), 64'(ifu_rvalid), 64'(!exp_lsu));
      chk($sformatf("v%0d_lsu_rvalid", idx), 64'(lsu_rvalid), 64'(exp_lsu));
      chk($sformatf("v%0d_rid", idx), exp_lsu ? 64'(lsu_rid) : 64'(ifu_rid),
          exp_lsu ? 64'h9 : 64'h5);
      chk($sformatf("v%0d_rresp", idx), exp_lsu ? 64'(lsu_rresp) : 64'(ifu_rresp), 64'(resp));
      chk($sformatf("v%0d_rready_o", idx), 64'(axi_r_ready_o), 64'(1));
      @(negedge clk);
      axi_r_valid_i = 0; axi_r_last_i = 0;
      #1 chk($sformatf("v%0d_back_idle", idx), 64'(axi_r_ready_o), 64'(0));
   endtask

   typedef struct {
      logic       ifu_v;
      logic       lsu_v;
      logic [1:0] rresp;
      logic       exp_lsu;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int got;
      // rr pointer starts at IFU and flips to the other master after each completed read.
      vecs[0] = '{1'b1, 1'b1, 2'b00, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 2'b00, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 2'b00, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 2'b00, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 2'b01, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 2'b00, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 2'b10, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 2'b00, 1'b1};

      zero_inputs();
      rst = 1;
      @(negedge clk); @(negedge clk);
      chk("reset_ar_valid", 64'(axi_ar_valid_o), 64'(0));
      chk("reset_r_ready", 64'(axi_r_ready_o), 64'(0));
      chk("reset_w_valid", 64'(axi_w_valid_o), 64'(0));
      chk("reset_b_ready", 64'(axi_b_ready_o), 64'(0));
      rst = 0;

      for (int i = 0; i < 8; i++)
         do_read(vecs[i].ifu_v, vecs[i].lsu_v, vecs[i].rresp, vecs[i].exp_lsu, i);

      // IFU 4-beat burst with a 3-cycle rready stall before beat 2.
      @(negedge clk);
      ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_arlen = 3; ifu_arid = 4'h6;
      #1 chk("burst_ar_lat0", 64'(axi_ar_valid_o), 64'(0));
      @(negedge clk);
      chk("burst_ar_valid", 64'(axi_ar_valid_o), 64'(1));
      chk("burst_ar_id", 64'(axi_ar_id_o), 64'(0));
      chk("burst_ar_addr", 64'(axi_ar_addr_o), 64'h8000_0000);
      chk("burst_ar_len", 64'(axi_ar_len_o), 64'(3));
      axi_ar_ready_i = 1;
      @(negedge clk);
      axi_ar_ready_i = 0; ifu_arvalid = 0; ifu_arid = 4'h2; ifu_arlen = 0;
      got = 0;
      for (int b = 0; b < 4; b++) begin
         if (b == 2) begin
            ifu_rready = 0; axi_r_valid_i = 1; axi_r_data_i = 64'hBEEF_0002; axi_r_last_i = 0;
            for (int s = 0; s < 3; s++) begin
               #1 chk("stall_rready_o", 64'(axi_r_ready_o), 64'(0));
               chk("stall_rvalid", 64'(ifu_rvalid), 64'(1));
               @(negedge clk);
            end
         end
         ifu_rready = 1; axi_r_valid_i = 1; axi_r_data_i = 64'hBEEF_0000 + 64'(b);
         axi_r_last_i = (b == 3);
         #1 chk("burst_rready_o", 64'(axi_r_ready_o), 64'(1));
         chk("burst_rid", 64'(ifu_rid), 64'h6);
         chk("burst_rdata", ifu_rdata, 64'hBEEF_0000 + 64'(b));
         chk("burst_lsu_rvalid", 64'(lsu_rvalid), 64'(0));
         if (ifu_rvalid && ifu_rready) got++;
         @(negedge clk);
      end
      axi_r_valid_i = 0; axi_r_last_i = 0;
      #1 chk("burst_beats", 64'(got), 64'(4));
      chk("burst_idle", 64'(axi_r_ready_o), 64'(0));

      // Store, then a load to the same address issued while the B response is pending.
      @(negedge clk);
      lsu_awvalid = 1; lsu_awaddr = 32'h8000_1000; lsu_awlen = 0; lsu_awid = 4'h3;
      axi_aw_ready_i = 1; lsu_wvalid = 1; lsu_wdata = 64'h1122_3344_5566_7788;
      lsu_wstrb = 8'hFF; lsu_wlast = 1; axi_w_ready_i = 1;
      #1 chk("aw_valid", 64'(axi_aw_valid_o), 64'(1));
      chk("aw_id", 64'(axi_aw_id_o), 64'(1));
      chk("aw_addr", 64'(axi_aw_addr_o), 64'h8000_1000);
      chk("aw_ready_up", 64'(lsu_awready), 64'(1));
      chk("w_blocked_idle", 64'(axi_w_valid_o), 64'(0));
      chk("wready_idle", 64'(lsu_wready), 64'(0));
      @(negedge clk);
      axi_aw_ready_i = 0;
      #1 chk("aw_blocked_wdata", 64'(axi_aw_valid_o), 64'(0));
      chk("w_valid", 64'(axi_w_valid_o), 64'(1));
      chk("w_strb", 64'(axi_w_strb_o), 64'hFF);
      chk("w_data", axi_w_data_o, 64'h1122_3344_5566_7788);
      chk("w_ready_up", 64'(lsu_wready), 64'(1));
      lsu_awvalid = 0;
      @(negedge clk);
      lsu_wvalid = 0; lsu_wlast = 0; axi_w_ready_i = 0; lsu_bready = 1;
      ifu_arvalid = 1; ifu_araddr = 32'h8000_0040; ifu_arid = 4'h7;
      lsu_arvalid = 1; lsu_araddr = 32'h8000_1000; lsu_arid = 4'hA;
      #1 chk("wresp_bready", 64'(axi_b_ready_o), 64'(1));
      chk("wresp_no_bvalid", 64'(lsu_bvalid), 64'(0));
      @(negedge clk);
      chk("ifu_during_wresp", 64'(axi_ar_valid_o), 64'(1));
      chk("ifu_during_wresp_id", 64'(axi_ar_id_o), 64'(0));
      axi_ar_ready_i = 1;
      #1 chk("lsu_arready_blocked", 64'(lsu_arready), 64'(0));
      @(negedge clk);
      axi_ar_ready_i = 0; ifu_arvalid = 0;
      axi_r_valid_i = 1; axi_r_last_i = 1; axi_r_resp_i = 0; ifu_rready = 1;
      #1 chk("wresp_ifu_rvalid", 64'(ifu_rvalid), 64'(1));
      chk("wresp_lsu_rvalid", 64'(lsu_rvalid), 64'(0));
      @(negedge clk);
      axi_r_valid_i = 0; axi_r_last_i = 0;
      #1 chk("after_ifu_idle", 64'(axi_ar_valid_o), 64'(0));
      @(negedge clk);
      chk("lsu_blocked", 64'(axi_ar_valid_o), 64'(0));
      axi_b_valid_i = 1; axi_b_resp_i = 2'b11; axi_b_id_i = 4'hC;
      #1 chk("b_valid", 64'(lsu_bvalid), 64'(1));
      chk("b_id", 64'(lsu_bid), 64'h3);
      chk("b_resp", 64'(lsu_bresp), 64'(3));
      @(negedge clk);
      axi_b_valid_i = 0;
      #1 chk("lsu_blocked_b_edge", 64'(axi_ar_valid_o), 64'(0));
      chk("b_done", 64'(axi_b_ready_o), 64'(0));
      @(negedge clk);
      chk("lsu_granted", 64'(axi_ar_valid_o), 64'(1));
      chk("lsu_granted_id", 64'(axi_ar_id_o), 64'(1));
      chk("lsu_granted_addr", 64'(axi_ar_addr_o), 64'h8000_1000);
      axi_ar_ready_i = 1;
      @(negedge clk);
      axi_ar_ready_i = 0; lsu_arvalid = 0;
      axi_r_valid_i = 1; axi_r_last_i = 1; axi_r_resp_i = 2'b10; lsu_rready = 1;
      #1 chk("lsu_rvalid", 64'(lsu_rvalid), 64'(1));
      chk("lsu_rid", 64'(lsu_rid), 64'hA);
      chk("lsu_rresp_err", 64'(lsu_rresp), 64'(2));
      @(negedge clk);
      axi_r_valid_i = 0; axi_r_last_i = 0; axi_r_resp_i = 0;
      #1 chk("lsu_read_done", 64'(axi_r_ready_o), 64'(0));

      // Leave rr_ptr pointing at LSU, then reset in the middle of an IFU burst.
      do_read(1'b1, 1'b0, 2'b00, 1'b0, 20);
      @(negedge clk);
      ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_arlen = 3; ifu_arid = 4'h6;
      @(negedge clk);
      axi_ar_ready_i = 1;
      @(negedge clk);
      axi_ar_ready_i = 0; ifu_arvalid = 0; ifu_rready = 1;
      axi_r_valid_i = 1; axi_r_last_i = 0;
      @(negedge clk); @(negedge clk);
      lsu_awvalid = 1; lsu_wvalid = 1; axi_b_valid_i = 1; axi_aw_ready_i = 1;
      axi_w_ready_i = 1; ifu_arvalid = 1; lsu_arvalid = 1; lsu_rready = 1; axi_ar_ready_i = 1;
      #2 rst = 1;
      #1 chk("rst_ifu_arready", 64'(ifu_arready), 64'(0));
      chk("rst_ifu_rvalid", 64'(ifu_rvalid), 64'(0));
      chk("rst_lsu_arready", 64'(lsu_arready), 64'(0));
      chk("rst_lsu_rvalid", 64'(lsu_rvalid), 64'(0));
      chk("rst_lsu_awready", 64'(lsu_awready), 64'(0));
      chk("rst_lsu_wready", 64'(lsu_wready), 64'(0));
      chk("rst_lsu_bvalid", 64'(lsu_bvalid), 64'(0));
      chk("rst_ar_valid", 64'(axi_ar_valid_o), 64'(0));
      chk("rst_r_ready", 64'(axi_r_ready_o), 64'(0));
      chk("rst_aw_valid", 64'(axi_aw_valid_o), 64'(0));
      chk("rst_w_valid", 64'(axi_w_valid_o), 64'(0));
      chk("rst_b_ready", 64'(axi_b_ready_o), 64'(0));
      @(negedge clk);
      rst = 0; axi_r_valid_i = 0; lsu_wvalid = 0; axi_b_valid_i = 0;
      axi_aw_ready_i = 0; axi_w_ready_i = 0; axi_ar_ready_i = 0;
      #1 chk("post_rst_w_idle", 64'(axi_aw_valid_o), 64'(1));
      chk("post_rst_r_idle", 64'(axi_ar_valid_o), 64'(0));
      @(negedge clk);
      chk("post_rst_tie_valid", 64'(axi_ar_valid_o), 64'(1));
      chk("post_rst_tie_ifu", 64'(axi_ar_id_o), 64'(0));
      zero_inputs();
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
